// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: digit-serial WIDTH-bit adder that processes one 4-bit
// nibble per clock, LSB nibble first, behind a valid/ready handshake on both
// the operand side and the result side.
module nibble_serial_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int unsigned N     = WIDTH / 4;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned LAST  = N - 1;

    // Reject widths that are not a whole number of nibbles or shorter than a byte
    generate
        if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
            $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    // Operand capture and serial datapath state
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [IDX_W-1:0] idx_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             out_valid_q;

    // Decoded control strobes for the current cycle
    logic accept_c;
    logic step_c;
    logic last_c;

    // Current nibble operands and the ripple-add results
    logic [3:0] nib_a_c;
    logic [3:0] nib_b_c;
    logic [3:0] nib_sum_c;
    logic       nib_cout_c;
    logic       nib_cmsb_c;

    // 4-bit ripple add returning {carry into bit 3, carry out of bit 3, sum}
    function automatic logic [5:0] add_nibble(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic       c
    );
        logic [4:0] cy;
        logic [3:0] s;
        cy[0] = c;
        for (int i = 0; i < 4; i++) begin
            s[i]      = a[i] ^ b[i] ^ cy[i];
            cy[i + 1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
        end
        return {cy[3], cy[4], s};
    endfunction

    // Select nibble k of each captured operand and add it with the running carry
    always_comb begin
        nib_a_c = a_q[{idx_q, 2'b00} +: 4];
        nib_b_c = b_q[{idx_q, 2'b00} +: 4];
        {nib_cmsb_c, nib_cout_c, nib_sum_c} = add_nibble(nib_a_c, nib_b_c, carry_q);
    end

    // Next-state and control decode
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        step_c   = 1'b0;
        last_c   = (idx_q == IDX_W'(LAST));
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    accept_c = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                step_c = 1'b1;
                if (last_c) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with handshake flags registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
        end
    end

    // Operand capture, per-nibble result write-back and final flag capture
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept_c) begin
            a_q     <= A;
            b_q     <= B;
            carry_q <= Cin;
            idx_q   <= '0;
        end else if (step_c) begin
            sum_q[{idx_q, 2'b00} +: 4] <= nib_sum_c;
            carry_q                    <= nib_cout_c;
            if (last_c) begin
                cout_q <= nib_cout_c;
                ovf_q  <= nib_cmsb_c ^ nib_cout_c;
            end else begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Sum       = sum_q;
    assign Cout      = cout_q;
    assign Ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Testbench for nibble_serial_adder (WIDTH=16): directed vector table,
// back-pressure / noisy-input / mid-run reset sequences, and random operations
// checked against a plain-arithmetic reference.
module tb_nibble_serial_adder;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned N     = WIDTH / 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Ovf;

    int errors;
    int checks;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .Cout      (Cout),
        .Ovf       (Ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: whole-word arithmetic, overflow from operand/result signs
    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         output logic [15:0] s, output logic c, output logic o);
        logic [16:0] full;
        full = 17'(a) + 17'(b) + 17'(cin);
        s = full[15:0];
        c = full[16];
        o = (a[15] == b[15]) && (s[15] != a[15]);
    endtask

    // Full transaction: accept, measure latency, check result, hold for stall cycles, release
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input int stall, input bit noisy, input string tag);
        logic [15:0] es;
        logic        ec;
        logic        eo;
        int          lat;
        bit          got;
        model(a, b, cin, es, ec, eo);
        lat = 0;
        while (!in_ready && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
        A = a; B = b; Cin = cin; in_valid = 1'b1;
        tick();
        if (!noisy) in_valid = 1'b0;
        chk({tag, " in_ready after accept"}, 32'(in_ready), 32'd0);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            A = 16'($urandom); B = 16'($urandom); Cin = 1'($urandom);
            tick();
            lat++;
            got = out_valid;
        end
        chk({tag, " latency"}, 32'(lat), 32'(N));
        chk({tag, " Sum"}, 32'(Sum), 32'(es));
        chk({tag, " Cout"}, 32'(Cout), 32'(ec));
        chk({tag, " Ovf"}, 32'(Ovf), 32'(eo));
        for (int i = 0; i < stall; i++) begin
            tick();
            chk({tag, " stall out_valid"}, 32'(out_valid), 32'd1);
            chk({tag, " stall Sum"}, 32'(Sum), 32'(es));
            chk({tag, " stall in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, " release out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " release in_ready"}, 32'(in_ready), 32'd1);
    endtask

    vec_t vecs[7];

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        bit          seen;

        errors = 0;
        checks = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; Cin = 1'b0;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1};
        vecs[4] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};

        tick();
        tick();
        rst = 1'b0;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset Sum", 32'(Sum), 32'd0);
        chk("reset Cout", 32'(Cout), 32'd0);
        chk("reset Ovf", 32'(Ovf), 32'd0);

        // Directed table: table expectations are hand values; also cross-check the model
        for (int i = 0; i < 7; i++) begin
            logic [15:0] ms;
            logic        mc;
            logic        mo;
            model(vecs[i].a, vecs[i].b, vecs[i].cin, ms, mc, mo);
            chk($sformatf("vec%0d table/model agree", i), {ms, 14'd0, mc, mo},
                {vecs[i].sum, 14'd0, vecs[i].cout, vecs[i].ovf});
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 0, 1'b0, $sformatf("vec%0d", i));
        end

        // Back-pressure: hold out_ready low for 3 cycles in DONE
        run_op(16'h1234, 16'h4321, 1'b0, 3, 1'b0, "stall3");

        // Noisy inputs: in_valid stays high and operands churn during RUN
        run_op(16'hA5A5, 16'h5A5B, 1'b1, 1, 1'b1, "noisy");

        // Mid-run reset on the second RUN cycle
        chk("abort pre in_ready", 32'(in_ready), 32'd1);
        A = 16'h1234; B = 16'h4321; Cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort in_ready", 32'(in_ready), 32'd1);
        chk("abort out_valid", 32'(out_valid), 32'd0);
        chk("abort Sum", 32'(Sum), 32'd0);
        chk("abort Cout", 32'(Cout), 32'd0);
        chk("abort Ovf", 32'(Ovf), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("abort no out_valid", 32'(seen), 32'd0);
        chk("abort idle in_ready", 32'(in_ready), 32'd1);

        // Random operations with random back-pressure
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            run_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom),
                   $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand width in bits; it SHALL be a multiple of 4 and at least 8.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: the reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the upstream operand set is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-006 The block SHALL have port A, input, WIDTH bits: operand A.
REQ-007 The block SHALL have port B, input, WIDTH bits: operand B.
REQ-008 The block SHALL have port Cin, input, 1 bit: the carry-in to nibble 0.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 The block SHALL have port Sum, output, WIDTH bits: the sum A+B+Cin modulo 2^WIDTH.
REQ-012 The block SHALL have port Cout, output, 1 bit: the carry out of the MSB.
REQ-013 The block SHALL have port Ovf, output, 1 bit: signed overflow (carry into MSB XOR carry out of MSB).

Function
REQ-014 The block SHALL compute the sum digit-serially, one 4-bit nibble per clock, LSB nibble first, using an internal 4-bit ripple add (per-bit sum = a^b^c, carry = a&b | c&(a^b)).
REQ-015 The FSM SHALL have states IDLE, RUN and DONE; N = WIDTH/4 SHALL be the nibble count.
REQ-016 in_ready SHALL be 1 only in IDLE.
REQ-017 Acceptance SHALL occur on an edge where in_valid=1 and in_ready=1: A, B and Cin are captured into internal registers, the nibble index is cleared to 0, the carry register is loaded with Cin, and the state goes IDLE->RUN.
REQ-018 Operand inputs SHALL be ignored outside an acceptance edge; in_valid=1 in RUN or DONE SHALL have no effect.
REQ-019 On each RUN edge, nibble k SHALL be added with the carry register, the 4-bit result written to Sum[4k+3:4k], the carry register updated, and k incremented.
REQ-020 On the edge that processes k=N-1, the block SHALL set Cout to the nibble carry out, set Ovf to the carry into bit WIDTH-1 XOR the carry out, and go RUN->DONE.
REQ-021 out_valid SHALL be 1 exactly in DONE and SHALL first assert N clock edges after the acceptance edge (4 cycles for WIDTH=16).
REQ-022 In DONE, Sum, Cout and Ovf SHALL be stable; the block SHALL remain in DONE while out_ready=0.
REQ-023 DONE with out_ready=1 SHALL go to IDLE on that edge; the next acceptance SHALL be possible at the earliest on the following edge, giving a minimum initiation interval of N+2 cycles.
REQ-024 Sum, Cout and Ovf SHALL keep their last values in IDLE, and SHALL be undefined to the consumer except while out_valid=1.
REQ-025 The nibble index SHALL never exceed N-1, and no wrap-around into a second pass SHALL occur.

Reset
REQ-026 With rst=1 at a clock edge, the state SHALL go to IDLE and in_ready SHALL be 1 after that edge; out_valid, Sum, Cout, Ovf, the carry register, the nibble index and the operand registers SHALL all be 0.
REQ-027 rst SHALL take priority over all other inputs in any state, including mid-RUN and DONE; a partially computed result SHALL be discarded and no out_valid SHALL follow.

Verification (WIDTH=16)
REQ-028 The bench SHALL check: A=0x1234, B=0x4321, Cin=0 -> out_valid 4 cycles after acceptance, Sum=0x5555, Cout=0, Ovf=0.
REQ-029 The bench SHALL check: A=0xFFFF, B=0x0001, Cin=0 -> Sum=0x0000, Cout=1, Ovf=0; and A=0x7FFF, B=0x0000, Cin=1 -> Sum=0x8000, Cout=0, Ovf=1.
REQ-030 The bench SHALL check: out_ready held 0 for 3 cycles in DONE -> out_valid stays 1, Sum is unchanged and in_ready stays 0; then out_ready=1 -> IDLE and in_ready=1 on the next cycle.
REQ-031 The bench SHALL check: in_valid held 1 with changing A/B during RUN -> the result reflects only the operands captured at acceptance.
REQ-032 The bench SHALL check: rst=1 on the second RUN cycle -> next cycle IDLE, in_ready=1, Sum=0, Cout=0, Ovf=0, and out_valid never asserts for the aborted operation.
REQ-033 The bench SHALL check: A=0x8000, B=0x8000, Cin=1 -> Sum=0x0001, Cout=1, Ovf=1.
